// File: rtl/score_scan_display_pkg.sv
// score_scan_display_pkg: shared FSM state, segment patterns and defaults for the score display.
package score_scan_display_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
    localparam int SCORE_W_DEF = 6;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_PATTERN [10] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };
endpackage

// File: rtl/score_scan_display_bcd_to_seg.sv
// bcd_to_seg: BCD nibble to abcdefg segment lookup; out-of-range nibbles go dark.
module bcd_to_seg
    import score_scan_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    always_comb seg = (bcd > 4'd9) ? SEG_BLANK : SEG_PATTERN[bcd];
endmodule

// File: rtl/score_scan_display.sv
// score_scan_display: double-dabble score to BCD, scanned onto two multiplexed 7-segment digits.
// Optional SCORE_SCAN_DISPLAY_BLANK_LZ_EN blanks a zero tens digit.
module score_scan_display
    import score_scan_display_pkg::*;
#(
    parameter int SCORE_W  = SCORE_W_DEF,
    parameter int SCAN_DIV = 50000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SCORE_W-1:0] score,
    input  logic               score_update,
    output logic [6:0]         seg,
    output logic [1:0]         dig,
    output logic               busy
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int NW = $clog2(SCORE_W + 1);

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] bin_q, bin_d, pend_score_q, pend_score_d;
    logic [3:0]         tens_q, tens_d, units_q, units_d;
    logic [3:0]         disp_tens_q, disp_tens_d, disp_units_q, disp_units_d;
    logic [NW-1:0]      nshift_q, nshift_d;
    logic               busy_q, busy_d, pend_q, pend_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               ptr_q, ptr_d;
    logic [6:0]         seg_q, seg_d, dec_seg;
    logic [1:0]         dig_q, dig_d;
    logic [3:0]         t_adj, u_adj, sel;
    logic [SCORE_W+7:0] sh;
    logic               tick, lz_blank;

    always_comb begin
        t_adj        = (tens_q >= 4'd5) ? tens_q + 4'd3 : tens_q;
        u_adj        = (units_q >= 4'd5) ? units_q + 4'd3 : units_q;
        sh           = {t_adj, u_adj, bin_q} << 1;
        state_d      = state_q;
        bin_d        = bin_q;
        tens_d       = tens_q;
        units_d      = units_q;
        nshift_d     = nshift_q;
        busy_d       = busy_q;
        disp_tens_d  = disp_tens_q;
        disp_units_d = disp_units_q;
        pend_d       = (score_update && state_q != IDLE) ? 1'b1 : pend_q;
        pend_score_d = (score_update && state_q != IDLE) ? score : pend_score_q;
        case (state_q)
            IDLE: if (score_update) begin
                bin_d    = score;
                tens_d   = '0;
                units_d  = '0;
                nshift_d = '0;
                busy_d   = 1'b1;
                state_d  = SHIFT;
            end
            SHIFT: begin
                {tens_d, units_d, bin_d} = sh;
                nshift_d = nshift_q + NW'(1);
                state_d  = (nshift_q == NW'(SCORE_W - 1)) ? COMMIT : SHIFT;
            end
            default: begin
                disp_tens_d  = tens_q;
                disp_units_d = units_q;
                // A request landing on this edge is newer than any pending one, so it wins.
                if (score_update || pend_q) begin
                    bin_d    = score_update ? score : pend_score_q;
                    tens_d   = '0;
                    units_d  = '0;
                    nshift_d = '0;
                    pend_d   = 1'b0;
                    state_d  = SHIFT;
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    bcd_to_seg u_dec (.bcd(sel), .seg(dec_seg));

    always_comb begin
        tick  = cnt_q == CW'(SCAN_DIV - 1);
        cnt_d = tick ? '0 : cnt_q + CW'(1);
        // The very first tick after reset lands on units rather than toggling.
        ptr_d = tick ? ((dig_q == 2'b00) ? 1'b0 : ~ptr_q) : ptr_q;
        sel   = ptr_d ? disp_tens_q : disp_units_q;
`ifdef SCORE_SCAN_DISPLAY_BLANK_LZ_EN
        lz_blank = ptr_d && disp_tens_q == 4'd0;
`else
        lz_blank = 1'b0;
`endif
        seg_d = tick ? (lz_blank ? SEG_BLANK : dec_seg) : seg_q;
        dig_d = tick ? (ptr_d ? 2'b10 : 2'b01) : dig_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            bin_q        <= '0;
            tens_q       <= '0;
            units_q      <= '0;
            nshift_q     <= '0;
            busy_q       <= 1'b0;
            pend_q       <= 1'b0;
            pend_score_q <= '0;
            disp_tens_q  <= '0;
            disp_units_q <= '0;
            cnt_q        <= '0;
            ptr_q        <= 1'b0;
            seg_q        <= SEG_BLANK;
            dig_q        <= 2'b00;
        end else begin
            state_q      <= state_d;
            bin_q        <= bin_d;
            tens_q       <= tens_d;
            units_q      <= units_d;
            nshift_q     <= nshift_d;
            busy_q       <= busy_d;
            pend_q       <= pend_d;
            pend_score_q <= pend_score_d;
            disp_tens_q  <= disp_tens_d;
            disp_units_q <= disp_units_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            seg_q        <= seg_d;
            dig_q        <= dig_d;
        end
    end

    assign seg  = seg_q;
    assign dig  = dig_q;
    assign busy = busy_q;
endmodule

// File: tb/tb_score_scan_display.sv
// tb_score_scan_display: directed checks of reset, conversion latency, pending requests and scan output.
module tb_score_scan_display;
    logic       clk, reset, score_update, busy;
    logic [5:0] score;
    logic [6:0] seg;
    logic [1:0] dig;
    int         n_chk = 0, n_pass = 0;

`ifdef SCORE_SCAN_DISPLAY_BLANK_LZ_EN
    localparam logic [6:0] TENS0 = 7'b0000000;
`else
    localparam logic [6:0] TENS0 = 7'b1111110;
`endif

    score_scan_display #(.SCORE_W(6), .SCAN_DIV(4)) dut (
        .clk(clk), .reset(reset), .score(score), .score_update(score_update),
        .seg(seg), .dig(dig), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_slot(input string tag, input logic [1:0] d, input logic [6:0] exp_seg);
        logic [1:0] prev;
        bit         ok = 0;
        for (int n = 0; n < 40 && !ok; n++) begin
            prev = dig;
            step();
            if (prev != d && dig == d) ok = 1;
        end
        check({tag, "_slot"}, 32'(ok), 32'd1);
        check({tag, "_seg"}, 32'(seg), 32'(exp_seg));
    endtask

    task automatic convert(input string tag, input logic [5:0] sc, input logic [5:0] sc2,
                           input int up_at, input int exp_busy);
        int n = 0;
        score        = sc;
        score_update = 1'b1;
        step();
        score_update = 1'b0;
        while (busy && n < 40) begin
            n++;
            score_update = (n == up_at);
            if (n == up_at) score = sc2;
            step();
        end
        score_update = 1'b0;
        check({tag, "_busy_cycles"}, 32'(n), 32'(exp_busy));
    endtask

    initial begin
        reset        = 1'b1;
        score        = '0;
        score_update = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            check("pre_tick_dig", 32'(dig), 32'd0);
            check("pre_tick_seg", 32'(seg), 32'd0);
        end
        check("pre_tick_busy", 32'(busy), 32'd0);
        step();
        check("tick1_dig", 32'(dig), 32'b01);
        check("tick1_seg", 32'(seg), 32'b1111110);
        repeat (3) step();
        check("tick1_hold_dig", 32'(dig), 32'b01);
        step();
        check("tick2_dig", 32'(dig), 32'b10);
        check("tick2_seg", 32'(seg), 32'(TENS0));

        convert("s42", 6'd42, 6'd0, 0, 7);
        wait_slot("s42_u", 2'b01, 7'b1101101);
        wait_slot("s42_t", 2'b10, 7'b0110011);

        convert("s63", 6'd63, 6'd0, 0, 7);
        wait_slot("s63_t", 2'b10, 7'b1011111);
        wait_slot("s63_u", 2'b01, 7'b1111001);

        convert("s9", 6'd9, 6'd0, 0, 7);
        wait_slot("s9_t", 2'b10, TENS0);
        wait_slot("s9_u", 2'b01, 7'b1111011);

        convert("s7", 6'd7, 6'd0, 0, 7);
        wait_slot("s7_t", 2'b10, TENS0);
        wait_slot("s7_u", 2'b01, 7'b1110000);

        convert("pend", 6'd10, 6'd25, 2, 14);
        wait_slot("pend_t", 2'b10, 7'b1101101);
        wait_slot("pend_u", 2'b01, 7'b1011011);

        score        = 6'd42;
        score_update = 1'b1;
        step();
        score_update = 1'b0;
        repeat (3) step();
        check("mid_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_seg", 32'(seg), 32'd0);
        check("abort_dig", 32'(dig), 32'd0);
        step();
        reset = 1'b0;
        wait_slot("abort_u", 2'b01, 7'b1111110);
        wait_slot("abort_t", 2'b10, TENS0);
        check("abort_idle_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
